dac_segment_ctrl: RTL and testbench

- Digital controller for the segmented current-steering DAC source array.
- Splits an input code into a thermometer-decoded MSB segment and a binary LSB segment.
- Applies data-weighted-averaging (DWA) rotation to the unary units and sequences bias settling on power-up/power-down (pdb).
- Exposes an internal debug word through the atb_ena testbus selector.
- Parametrised successor to the fixed 16-unit/6-bit source block: generalised in segment widths, with the DWA and sequencing behaviour that block lacks.

---
 rtl/dac_segment_ctrl.sv | 127 ++++++++++++
 tb/tb_dac_segment_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_segment_ctrl.sv
// Segmented current-steering DAC controller: thermometer MSB units with DWA rotation,
// binary LSB selects, and bias settle sequencing driven by pdb. Debug word on the testbus.
// Selects and debug word are registered with 1-cycle latency; codes are ignored outside ACTIVE.
module dac_segment_ctrl #(
   parameter int THERM_BITS = 4,
   parameter int BIN_BITS   = 6,
   parameter int SETTLE_CYC = 16
) (
   input  logic                             clk,
   input  logic                             rstb,
   input  logic                             pdb,
   input  logic                             dem_en,
   input  logic [THERM_BITS+BIN_BITS-1:0]   code_in,
   input  logic                             code_vld,
   input  logic [1:0]                       atb_ena,
   output logic                             bias_en,
   output logic                             dac_ready,
   output logic [(2**THERM_BITS)-2:0]       therm_sel,
   output logic [BIN_BITS-1:0]              bin_sel,
   output logic                             bin0_red,
   output logic [THERM_BITS+BIN_BITS-1:0]   atb_dbg
);

   localparam int NUM_UNITS = (2**THERM_BITS) - 1;
   localparam int CODE_W    = THERM_BITS + BIN_BITS;
   localparam int CNT_W     = $clog2(SETTLE_CYC + 1);
   // NUM_UNITS expressed in the widened (THERM_BITS+1) arithmetic domain
   localparam logic [THERM_BITS:0] NU_EXT = {1'b0, {THERM_BITS{1'b1}}};

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      SETTLE = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       settle_cnt;
   logic [THERM_BITS-1:0]  ptr;
   logic [THERM_BITS-1:0]  ptr_nxt;
   logic [THERM_BITS-1:0]  n_units;
   logic [THERM_BITS:0]    ptr_sum;
   logic [THERM_BITS:0]    unit_idx;
   logic [NUM_UNITS-1:0]   therm_nxt;
   logic [CODE_W-1:0]      last_code;

   assign n_units   = code_in[CODE_W-1:BIN_BITS];
   assign bias_en   = (state != OFF);
   assign dac_ready = (state == ACTIVE);
   assign bin0_red  = bin_sel[0];

   // State register
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state <= OFF;
      else       state <= state_nxt;
   end

   // Next-state: pdb low always wins; SETTLE lasts exactly SETTLE_CYC cycles
   always_comb begin
      state_nxt = state;
      if (!pdb) begin
         state_nxt = OFF;
      end else begin
         case (state)
            OFF:     state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = ACTIVE;
            ACTIVE:  state_nxt = ACTIVE;
            default: state_nxt = OFF;
         endcase
      end
   end

   // Settle counter runs only while settling; any exit clears it so a re-raise restarts fully
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)                       settle_cnt <= '0;
      else if (state == SETTLE && pdb) settle_cnt <= settle_cnt + 1'b1;
      else                             settle_cnt <= '0;
   end

   // Unary decode: n consecutive units starting at ptr (or unit 0), wrapping mod NUM_UNITS
   always_comb begin
      therm_nxt = '0;
      unit_idx  = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         unit_idx = (dem_en ? {1'b0, ptr} : '0) + (THERM_BITS+1)'(i);
         if (unit_idx >= NU_EXT) unit_idx = unit_idx - NU_EXT;
         if (i < int'(n_units)) therm_nxt[unit_idx[THERM_BITS-1:0]] = 1'b1;
      end
      // ptr < NUM_UNITS and n <= NUM_UNITS, so one conditional subtract is a full modulo
      ptr_sum = {1'b0, ptr} + {1'b0, n_units};
      if (ptr_sum >= NU_EXT) ptr_sum = ptr_sum - NU_EXT;
      ptr_nxt = dem_en ? ptr_sum[THERM_BITS-1:0] : ptr;
   end

   // Selects, rotation pointer and last code: cleared outside ACTIVE, loaded on accepted codes
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         therm_sel <= '0;
         bin_sel   <= '0;
         ptr       <= '0;
         last_code <= '0;
      end else if (state != ACTIVE || !pdb) begin
         therm_sel <= '0;
         bin_sel   <= '0;
      end else if (code_vld) begin
         therm_sel <= therm_nxt;
         bin_sel   <= code_in[BIN_BITS-1:0];
         ptr       <= ptr_nxt;
         last_code <= code_in;
      end
   end

   // Testbus debug word, registered
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         atb_dbg <= '0;
      end else begin
         case (atb_ena)
            2'b00:   atb_dbg <= '0;
            2'b01:   atb_dbg <= CODE_W'(ptr);
            2'b10:   atb_dbg <= CODE_W'(state);
            default: atb_dbg <= last_code;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_segment_ctrl.sv
// Bench for dac_segment_ctrl: directed scenarios plus randomized traffic.
// Reference model tracks power state, rotation pointer and selects with plain integer arithmetic.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_dac_segment_ctrl;

   localparam int SETTLE = 16;
   localparam int NU     = 15;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        pdb = 1'b0;
   logic        dem_en = 1'b0;
   logic [9:0]  code_in = '0;
   logic        code_vld = 1'b0;
   logic [1:0]  atb_ena = 2'b00;
   logic        bias_en, dac_ready, bin0_red;
   logic [14:0] therm_sel;
   logic [5:0]  bin_sel;
   logic [9:0]  atb_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: 0 = off, 1 = settling, 2 = active
   int          m_state = 0;
   int          m_left  = 0;
   int          m_ptr   = 0;
   logic [14:0] m_therm = '0;
   logic [5:0]  m_bin   = '0;
   logic [9:0]  m_last  = '0;
   logic [9:0]  m_dbg   = '0;

   dac_segment_ctrl #(.THERM_BITS(4), .BIN_BITS(6), .SETTLE_CYC(SETTLE)) dut (
      .clk(clk), .rstb(rstb), .pdb(pdb), .dem_en(dem_en), .code_in(code_in),
      .code_vld(code_vld), .atb_ena(atb_ena), .bias_en(bias_en), .dac_ready(dac_ready),
      .therm_sel(therm_sel), .bin_sel(bin_sel), .bin0_red(bin0_red), .atb_dbg(atb_dbg)
   );

   always #5 clk = ~clk;

   // n lit units starting at unit p, as a 15-bit circular rotation of a low-order mask
   function automatic logic [14:0] unary(int n, int p);
      int m;
      m = (1 << n) - 1;
      return 15'(((m << p) | (m >> (NU - p))) & 32'h7FFF);
   endfunction

   function automatic logic [33:0] dut_vec();
      return {bias_en, dac_ready, therm_sel, bin_sel, bin0_red, atb_dbg};
   endfunction

   function automatic logic [33:0] mdl_vec();
      return {(m_state != 0), (m_state == 2), m_therm, m_bin, m_bin[0], m_dbg};
   endfunction

   task automatic model_reset();
      m_state = 0; m_left = 0; m_ptr = 0;
      m_therm = '0; m_bin = '0; m_last = '0; m_dbg = '0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_edge();
      int n;
      logic [9:0] dbg_n;
      case (atb_ena)
         2'b00:   dbg_n = '0;
         2'b01:   dbg_n = 10'(m_ptr);
         2'b10:   dbg_n = 10'(m_state);
         default: dbg_n = m_last;
      endcase
      if (!pdb) begin
         m_state = 0; m_therm = '0; m_bin = '0;
      end else if (m_state == 0) begin
         m_state = 1; m_left = SETTLE;
      end else if (m_state == 1) begin
         m_left = m_left - 1;
         if (m_left == 0) m_state = 2;
      end else if (code_vld) begin
         n = int'(code_in[9:6]);
         m_therm = dem_en ? unary(n, m_ptr) : unary(n, 0);
         if (dem_en) m_ptr = (m_ptr + n) % NU;
         m_bin  = code_in[5:0];
         m_last = code_in;
      end
      m_dbg = dbg_n;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      if (dut_vec() !== 34'd0) begin
         n_fail++; $display("FAIL reset_outputs got=%h want=0", dut_vec());
      end
      n_tests++;
      repeat (2) @(posedge clk);
      #1;
      if (dut_vec() !== 34'd0) begin
         n_fail++; $display("FAIL reset_held got=%h want=0", dut_vec());
      end
      n_tests++;
      rstb = 1'b1;
      step();
      if (dut_vec() !== mdl_vec()) begin
         n_fail++; $display("FAIL off_idle got=%h want=%h", dut_vec(), mdl_vec());
      end
      n_tests++;
   endtask

   task automatic test_settle();
      pdb = 1'b1;
      step();
      if (bias_en !== 1'b1 || dac_ready !== 1'b0) begin
         n_fail++; $display("FAIL settle_bias_rise got=%b%b want=10", bias_en, dac_ready);
      end
      n_tests++;
      for (int k = 2; k <= SETTLE; k++) begin
         code_vld = k[0];
         code_in  = 10'($urandom);
         step();
         if (dac_ready !== 1'b0 || therm_sel !== 15'd0 || bin_sel !== 6'd0 ||
             dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL settle_quiet cyc=%0d got=%h want=%h", k, dut_vec(), mdl_vec());
         end
         n_tests++;
      end
      code_vld = 1'b0;
      step();
      if (dac_ready !== 1'b1 || bias_en !== 1'b1) begin
         n_fail++; $display("FAIL settle_ready_17 got=%b want=1", dac_ready);
      end
      n_tests++;
   endtask

   task automatic test_dwa();
      int          ns[3]  = '{3, 5, 10};
      logic [14:0] exp[3] = '{15'h0007, 15'h00F8, 15'h7F07};
      dem_en = 1'b1; atb_ena = 2'b01;
      for (int k = 0; k < 3; k++) begin
         code_in  = {4'(ns[k]), 6'($urandom)};
         code_vld = 1'b1;
         step();
         if (therm_sel !== exp[k] || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL dwa_n%0d therm got=%h want=%h", ns[k], therm_sel, exp[k]);
         end
         n_tests++;
      end
      code_vld = 1'b0;
      step();
      if (atb_dbg !== 10'd3 || therm_sel !== 15'h7F07) begin
         n_fail++; $display("FAIL dwa_ptr got=%0d want=3", atb_dbg);
      end
      n_tests++;
   endtask

   task automatic test_binary();
      dem_en = 1'b0; code_in = 10'b0011_101101; code_vld = 1'b1;
      step();
      if (bin_sel !== 6'b101101 || bin0_red !== 1'b1 || therm_sel !== 15'h0007) begin
         n_fail++; $display("FAIL bin_path got=%b/%b want=101101/1", bin_sel, bin0_red);
      end
      n_tests++;
      dem_en = 1'b1; code_in = {4'd15, 6'b000010};
      step();
      if (therm_sel !== 15'h7FFF || bin0_red !== 1'b0 || dut_vec() !== mdl_vec()) begin
         n_fail++; $display("FAIL full_scale got=%h want=7fff", therm_sel);
      end
      n_tests++;
   endtask

   task automatic test_fixed();
      logic [5:0] b = '0;
      dem_en = 1'b0; atb_ena = 2'b01;
      for (int k = 0; k < 3; k++) begin
         b = 6'($urandom); code_in = {4'd4, b}; code_vld = 1'b1;
         step();
         if (therm_sel !== 15'h000F || bin_sel !== b) begin
            n_fail++; $display("FAIL fixed_%0d got=%h want=000f", k, therm_sel);
         end
         n_tests++;
      end
      code_vld = 1'b0; code_in = 10'($urandom);
      step();
      if (atb_dbg !== 10'd3 || therm_sel !== 15'h000F || bin_sel !== b ||
          dut_vec() !== mdl_vec()) begin
         n_fail++; $display("FAIL fixed_hold got=%h dbg=%0d want dbg=3", therm_sel, atb_dbg);
      end
      n_tests++;
   endtask

   task automatic test_powerdown();
      int cyc = 0;
      pdb = 1'b0; code_vld = 1'b1; dem_en = 1'b1; code_in = {4'd7, 6'h3F};
      step();
      if (dut_vec() !== {2'b00, 15'd0, 6'd0, 1'b0, atb_dbg} || dut_vec() !== mdl_vec()) begin
         n_fail++; $display("FAIL pd_outputs got=%h want=%h", dut_vec(), mdl_vec());
      end
      n_tests++;
      code_vld = 1'b0; atb_ena = 2'b01;
      step();
      if (atb_dbg !== 10'd3) begin
         n_fail++; $display("FAIL pd_ptr_kept got=%0d want=3", atb_dbg);
      end
      n_tests++;
      pdb = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         cyc = k;
         if (dac_ready === 1'b1) break;
      end
      if (cyc != SETTLE + 1 || dac_ready !== 1'b1) begin
         n_fail++; $display("FAIL pd_resettle cycles got=%0d want=%0d", cyc, SETTLE + 1);
      end
      n_tests++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int k = 0; k < 400; k++) begin
         pdb      = ($urandom_range(0, 49) != 0);
         dem_en   = ($urandom_range(0, 3) != 0);
         code_vld = $urandom_range(0, 1) == 1;
         code_in  = 10'($urandom);
         atb_ena  = 2'($urandom);
         step();
         if (dut_vec() !== mdl_vec()) begin
            errs++;
            if (errs <= 5) $display("FAIL random cyc=%0d got=%h want=%h", k, dut_vec(), mdl_vec());
         end
      end
      if (errs != 0) n_fail++;
      n_tests++;
   endtask

   task automatic test_async_reset();
      int cyc = 0;
      pdb = 1'b1; code_vld = 1'b0;
      for (int k = 1; k <= 40 && dac_ready !== 1'b1; k++) step();
      if (dac_ready !== 1'b1) begin
         n_fail++; $display("FAIL ar_reach_active got=%b want=1", dac_ready);
      end
      n_tests++;
      code_in = {4'd6, 6'h2A}; code_vld = 1'b1;
      step();
      code_vld = 1'b0;
      #3 rstb = 1'b0;
      #1;
      model_reset();
      if (dut_vec() !== 34'd0) begin
         n_fail++; $display("FAIL ar_immediate got=%h want=0", dut_vec());
      end
      n_tests++;
      #2 rstb = 1'b1;
      step();
      atb_ena = 2'b00; step();
      if (atb_dbg !== 10'd0) begin
         n_fail++; $display("FAIL atb_00 got=%0d want=0", atb_dbg);
      end
      n_tests++;
      atb_ena = 2'b01; step();
      if (atb_dbg !== 10'd0) begin
         n_fail++; $display("FAIL atb_01 got=%0d want=0", atb_dbg);
      end
      n_tests++;
      atb_ena = 2'b10; step();
      if (atb_dbg !== 10'd1) begin
         n_fail++; $display("FAIL atb_10 got=%0d want=1", atb_dbg);
      end
      n_tests++;
      for (int k = 1; k <= 40 && dac_ready !== 1'b1; k++) begin
         step();
         cyc = k;
      end
      step();
      if (atb_dbg !== 10'd2) begin
         n_fail++; $display("FAIL atb_10_active got=%0d want=2", atb_dbg);
      end
      n_tests++;
      dem_en = 1'b0; code_in = {4'd9, 6'h15}; code_vld = 1'b1;
      step();
      code_vld = 1'b0; atb_ena = 2'b11;
      step();
      if (atb_dbg !== {4'd9, 6'h15} || dut_vec() !== mdl_vec()) begin
         n_fail++; $display("FAIL atb_11 got=%h want=%h (waited %0d)", atb_dbg, {4'd9, 6'h15}, cyc);
      end
      n_tests++;
   endtask

   initial begin
      test_reset();
      test_settle();
      test_dwa();
      test_binary();
      test_fixed();
      test_powerdown();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
